// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the registered ALU control decoder: control codes,
// AluOp selectors and the multiply/divide sequencer state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlFn5 = 4'b0101;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlMul = 4'b1000;
  localparam logic [3:0] CtrlDiv = 4'b1001;

  localparam int unsigned AluOpRtype = 1;
  localparam int unsigned AluOpMd    = 7;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // R-type operation code from the low three funct bits.
  function automatic logic [3:0] rtype_code(input logic [2:0] f);
    logic [3:0] code;
    code = CtrlAnd;
    unique case (f)
      3'b000: code = CtrlSub;
      3'b001: code = CtrlAnd;
      3'b010: code = CtrlAdd;
      3'b011: code = CtrlOr;
      3'b100: code = CtrlFn5;
      3'b101: code = CtrlSlt;
      3'b110: code = CtrlFn5;
      3'b111: code = CtrlSlt;
      default: code = CtrlAnd;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational funct/AluOp decoder producing the ALU control word plus
// multiply/divide and illegal-op flags.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNC_W      = 3,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned ALUOP_RTYPE = AluOpRtype,
  parameter int unsigned ALUOP_MD    = AluOpMd
) (
  input  logic [FUNC_W-1:0]  i_func,
  input  logic [ALUOP_W-1:0] i_alu_op,
  output logic [CTRL_W-1:0]  o_ctrl,
  output logic               o_is_md,
  output logic               o_is_div,
  output logic               o_illegal
);

  logic w_func_hi;
  logic w_rtype;
  logic w_md;

  // Only func[2:0] carries the operation; any higher bit set is illegal.
  assign w_func_hi = (i_func >> 3) != '0;
  assign w_rtype   = i_alu_op == ALUOP_W'(ALUOP_RTYPE);
  assign w_md      = i_alu_op == ALUOP_W'(ALUOP_MD);

  always_comb begin
    o_ctrl    = '0;
    o_is_md   = 1'b0;
    o_is_div  = 1'b0;
    o_illegal = 1'b0;
    if (w_rtype || w_md) begin
      if (w_func_hi) begin
        o_ctrl    = '1;
        o_illegal = 1'b1;
      end else if (w_rtype) begin
        o_ctrl = CTRL_W'(rtype_code(i_func[2:0]));
      end else begin
        o_is_md  = 1'b1;
        o_is_div = i_func[0];
        o_ctrl   = i_func[0] ? CTRL_W'(CtrlDiv) : CTRL_W'(CtrlMul);
      end
    end else begin
      o_ctrl = CTRL_W'(i_alu_op[2:0]);
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a latency-counting sequencer for
// multi-cycle multiply/divide operations.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNC_W      = 3,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned ALUOP_RTYPE = AluOpRtype,
  parameter int unsigned ALUOP_MD    = AluOpMd,
  parameter int unsigned MUL_LAT     = 4,
  parameter int unsigned DIV_LAT     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [FUNC_W-1:0]  i_func,
  input  logic [ALUOP_W-1:0] i_alu_op,
  input  logic               i_stall_in,
  input  logic               i_flush,
  output logic               o_out_valid,
  output logic [CTRL_W-1:0]  o_alu_ctrl,
  output logic               o_illegal,
  output logic               o_md_start,
  output logic               o_md_busy,
  output logic               o_md_done
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic              r_illegal;
  logic              r_md_start;
  logic              r_md_busy;
  logic              r_md_done;

  logic [CTRL_W-1:0] w_ctrl;
  logic              w_is_md;
  logic              w_is_div;
  logic              w_illegal;
  logic              w_accept;
  logic [CntW-1:0]   w_lat_m1;
  logic              w_lat_one;

  alu_ctrl_decode #(
    .FUNC_W      (FUNC_W),
    .ALUOP_W     (ALUOP_W),
    .CTRL_W      (CTRL_W),
    .ALUOP_RTYPE (ALUOP_RTYPE),
    .ALUOP_MD    (ALUOP_MD)
  ) u_decode (
    .i_func    (i_func),
    .i_alu_op  (i_alu_op),
    .o_ctrl    (w_ctrl),
    .o_is_md   (w_is_md),
    .o_is_div  (w_is_div),
    .o_illegal (w_illegal)
  );

  assign o_in_ready = (r_state == StIdle) && !i_stall_in;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_lat_m1   = w_is_div ? CntW'(DIV_LAT - 1) : CntW'(MUL_LAT - 1);
  assign w_lat_one  = w_is_div ? (DIV_LAT == 1) : (MUL_LAT == 1);

  // md_done/out_valid are registered one cycle early (at count 1) so they
  // appear while the counter reads 0; the FSM leaves RUN after that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= '0;
      r_illegal   <= 1'b0;
      r_md_start  <= 1'b0;
      r_md_busy   <= 1'b0;
      r_md_done   <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      r_md_done  <= 1'b0;
      if (i_flush) begin
        r_state     <= StIdle;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_illegal   <= 1'b0;
        r_md_busy   <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_accept) begin
              r_alu_ctrl <= w_ctrl;
              r_illegal  <= w_illegal;
              if (w_is_md) begin
                r_md_start  <= 1'b1;
                r_md_busy   <= !w_lat_one;
                r_md_done   <= w_lat_one;
                r_out_valid <= w_lat_one;
                r_cnt       <= w_lat_m1;
                r_state     <= StRun;
              end else begin
                r_out_valid <= 1'b1;
              end
            end else if (!i_stall_in) begin
              r_out_valid <= 1'b0;
            end
          end
          StRun: begin
            if (r_cnt == CntW'(1)) begin
              r_md_done   <= 1'b1;
              r_out_valid <= 1'b1;
              r_md_busy   <= 1'b0;
            end else if (r_cnt == '0 && !i_stall_in) begin
              r_out_valid <= 1'b0;
            end
            if (r_cnt == '0) begin
              r_state <= StIdle;
            end else begin
              r_cnt <= r_cnt - CntW'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_alu_ctrl  = r_alu_ctrl;
  assign o_illegal   = r_illegal;
  assign o_md_start  = r_md_start;
  assign o_md_busy   = r_md_busy;
  assign o_md_done   = r_md_done;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: stimulus pushes expected outputs,
// a negedge monitor pops and compares each new valid output.
module tb_alu_control_seq;
  import alu_ctrl_pkg::*;

  localparam int unsigned FuncW  = 6;
  localparam int unsigned AluOpW = 3;
  localparam int unsigned CtrlW  = 4;
  localparam int unsigned MulLat = 4;
  localparam int unsigned DivLat = 16;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       done;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [FuncW-1:0]  i_func = '0;
  logic [AluOpW-1:0] i_alu_op = '0;
  logic              i_stall_in = 1'b0;
  logic              i_flush = 1'b0;
  logic              o_out_valid;
  logic [CtrlW-1:0]  o_alu_ctrl;
  logic              o_illegal;
  logic              o_md_start;
  logic              o_md_busy;
  logic              o_md_done;

  exp_t sb_q[$];
  exp_t last_exp = '0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_ov = 1'b0;
  logic prev_stall = 1'b0;
  logic [3:0] rtab [8] = '{4'b0110, 4'b0000, 4'b0010, 4'b0001,
                           4'b0101, 4'b0111, 4'b0101, 4'b0111};

  always #5 clk = ~clk;

  alu_control_seq #(
    .FUNC_W  (FuncW),
    .ALUOP_W (AluOpW),
    .CTRL_W  (CtrlW),
    .MUL_LAT (MulLat),
    .DIV_LAT (DivLat)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_func      (i_func),
    .i_alu_op    (i_alu_op),
    .i_stall_in  (i_stall_in),
    .i_flush     (i_flush),
    .o_out_valid (o_out_valid),
    .o_alu_ctrl  (o_alu_ctrl),
    .o_illegal   (o_illegal),
    .o_md_start  (o_md_start),
    .o_md_busy   (o_md_busy),
    .o_md_done   (o_md_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic ill, input logic d);
    exp_t e;
    e.ctrl    = c;
    e.illegal = ill;
    e.done    = d;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one single-cycle request for exactly one clock and log its result.
  task automatic req(input logic [2:0] op, input logic [5:0] f, input logic [3:0] ec,
                     input logic eill);
    i_in_valid = 1'b1;
    i_alu_op   = op;
    i_func     = f;
    sb_q.push_back(mk(ec, eill, 1'b0));
    cyc();
  endtask

  task automatic run_md(input logic div, input int lat, input logic stall_run,
                        input logic hold_req);
    i_in_valid = 1'b1;
    i_alu_op   = 3'd7;
    i_func     = div ? 6'd1 : 6'd0;
    sb_q.push_back(mk(div ? 4'b1001 : 4'b1000, 1'b0, 1'b1));
    cyc();
    i_in_valid = 1'b0;
    i_stall_in = stall_run;
    if (hold_req) begin
      i_in_valid = 1'b1;
      i_alu_op   = 3'd1;
      i_func     = 6'd2;
      sb_q.push_back(mk(4'b0010, 1'b0, 1'b0));
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("md_start", o_md_start, k == 1);
      chk("md_busy", o_md_busy, k < lat);
      chk("md_done_time", o_md_done, k == lat);
      chk("md_out_valid", o_out_valid, k == lat);
      chk("ready_in_run", o_in_ready, 0);
    end
    if (hold_req) begin
      @(negedge clk);
      chk("ready_after_done", o_in_ready, 1);
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      i_stall_in = 1'b0;
    end
  endtask

  // Launch a divide, then kill it on the 5th RUN cycle with flush or reset.
  task automatic abort_md(input logic use_reset);
    logic seen;
    seen       = 1'b0;
    i_in_valid = 1'b1;
    i_alu_op   = 3'd7;
    i_func     = 6'd1;
    cyc();
    i_in_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("abort_pre_busy", o_md_busy, 1);
    if (use_reset) reset = 1'b1;
    else i_flush = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    i_flush = 1'b0;
    @(negedge clk);
    chk("abort_busy", o_md_busy, 0);
    chk("abort_out_valid", o_out_valid, 0);
    chk("abort_illegal", o_illegal, 0);
    chk("abort_done", o_md_done, 0);
    chk("abort_ready", o_in_ready, 1);
    if (use_reset) begin
      chk("reset_ctrl", o_alu_ctrl, 0);
      chk("reset_start", o_md_start, 0);
    end
    repeat (20) begin
      @(negedge clk);
      seen = seen | o_md_done;
    end
    chk("abort_no_done", seen, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    logic is_new;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        is_new = o_out_valid && !(prev_ov && prev_stall);
        if (is_new) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got ctrl %0h with no expected entry", o_alu_ctrl);
          end else begin
            e        = sb_q.pop_front();
            last_exp = e;
            chk("sb_ctrl", o_alu_ctrl, e.ctrl);
            chk("sb_illegal", o_illegal, e.illegal);
            chk("sb_done", o_md_done, e.done);
          end
        end else if (o_out_valid) begin
          chk("hold_ctrl", o_alu_ctrl, last_exp.ctrl);
          chk("hold_illegal", o_illegal, last_exp.illegal);
        end else begin
          chk("done_without_valid", o_md_done, 0);
        end
        prev_ov    = o_out_valid;
        prev_stall = i_stall_in;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_ctrl", o_alu_ctrl, 0);
    chk("rst_illegal", o_illegal, 0);
    chk("rst_start", o_md_start, 0);
    chk("rst_busy", o_md_busy, 0);
    chk("rst_done", o_md_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) req(3'd1, 6'(i), rtab[i], 1'b0);
    req(3'd2, 6'd0, 4'b0010, 1'b0);
    req(3'd0, 6'd0, 4'b0000, 1'b0);
    i_in_valid = 1'b0;
    repeat (2) cyc();

    run_md(1'b0, MulLat, 1'b0, 1'b1);
    repeat (2) cyc();
    run_md(1'b1, DivLat, 1'b0, 1'b0);
    repeat (2) cyc();
    run_md(1'b1, DivLat, 1'b1, 1'b0);
    repeat (2) cyc();

    abort_md(1'b0);
    abort_md(1'b1);

    // A request coinciding with flush must be dropped.
    i_in_valid = 1'b1;
    i_alu_op   = 3'd1;
    i_func     = 6'd0;
    i_flush    = 1'b1;
    cyc();
    i_in_valid = 1'b0;
    i_flush    = 1'b0;
    @(negedge clk);
    chk("flush_drop_ov", o_out_valid, 0);
    @(posedge clk);
    #1;

    req(3'd1, 6'b001010, 4'b1111, 1'b1);
    i_in_valid = 1'b0;
    i_stall_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ctrl", o_alu_ctrl, 4'b1111);
      chk("stall_ready", o_in_ready, 0);
      chk("stall_out_valid", o_out_valid, 1);
    end
    @(posedge clk);
    #1;
    i_stall_in = 1'b0;

    req(3'd7, 6'b001000, 4'b1111, 1'b1);
    i_in_valid = 1'b0;
    i_flush    = 1'b1;
    cyc();
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_clr_illegal", o_illegal, 0);
    chk("flush_clr_ov", o_out_valid, 0);
    repeat (3) cyc();

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
